gate_unit_arbiter: RTL and testbench
====================================

Name: gate_unit_arbiter

Overview:
- Shares one bitwise two-input logic unit between N_REQ requesters. The unit supports AND, OR, XOR, XNOR, NAND, NOR, NOT and BUF.
- A round-robin arbiter picks one requester and captures its operands. The result is returned through a valid/ready response port, tagged with the requester ID.
- Sits between the gate-level datapath and the blocks that want gate results. It removes the need to replicate gate logic for each client.

Parameters:
- N_REQ, 4, number of requesters (2..16, power of two not required).
- WIDTH, 8, operand and result width in bits.
- IDW, 2, width of the requester ID. Must satisfy 2^IDW >= N_REQ.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester request; held high until the matching gnt is seen.
- op  in  3*N_REQ  per-requester opcode; requester i uses bits [3i+2:3i].
- a  in  WIDTH*N_REQ  per-requester operand A, packed the same way as op.
- b  in  WIDTH*N_REQ  per-requester operand B, packed the same way as op.
- gnt  out  N_REQ  one-hot, one-cycle pulse: the operands of that requester were captured.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_data  out  WIDTH  result.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: on the first edge with rst=1, all outputs go to 0, state=IDLE and ptr=0. Reset in any state, including EXEC or HOLD, discards the in-flight operation; no response is produced for it.
- Opcodes:
  - 0 = AND, 1 = OR, 2 = XOR, 3 = XNOR, 4 = NAND, 5 = NOR.
  - 6 = NOT a (b ignored).
  - 7 = BUF a (b ignored).
  - Operations are bitwise across WIDTH bits.
- Arbitration:
  - Round-robin, searching from index ptr upward and wrapping at N_REQ-1 back to 0.
  - The first requester with req=1 wins.
  - After a capture, ptr = (winner+1) mod N_REQ. ptr is unchanged when nothing is captured.
- State machine:
  - IDLE: if any req is high, at the edge capture the winner's op/a/b/id, go to EXEC, and gnt[winner]=1 for the EXEC cycle. Otherwise stay in IDLE.
  - EXEC: the logic unit evaluates the captured operands. At the edge: rsp_valid=1, rsp_data=result, rsp_id=captured id, gnt=0, go to HOLD.
  - HOLD: rsp_valid, rsp_data and rsp_id stay stable while rsp_ready=0.
  - HOLD with rsp_ready=1: at the edge rsp_valid=0. If any req is high, capture the next winner and go to EXEC (back-to-back); otherwise go to IDLE.
- Latency: req high in IDLE at cycle T gives gnt at T+1 and rsp_valid at T+2. Peak throughput is one result every 2 cycles.
- Requester rule: a requester drops req on the edge after seeing its gnt. Its req is therefore never re-sampled for the same operation, because no arbitration happens in EXEC.
- Operand capture: op/a/b are sampled only on the capture edge. Later changes to them have no effect.
- Simultaneous requests: exactly one grant per capture; the others wait. No requester is starved; the worst-case wait is N_REQ-1 operations.
- Deasserting req: if a requester drops req before it is captured, the request is silently withdrawn.
- An index in N_REQ..2^IDW-1 is never granted.

Decomposition:
- Shared package gate_pkg:
  - localparams OP_AND..OP_BUF (3-bit encodings as listed above).
  - State encodings ST_IDLE, ST_EXEC, ST_HOLD.
- Sub-module logic_gate_alu: combinational, parameter WIDTH, inputs op/a/b, output y.
  - Reused by later gate-level blocks.
  - Instantiated once here, fed from the capture registers.
- Round-robin pick stays inline as a small function.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all req high -> gnt=0, rsp_valid=0, busy=0, rsp_data=0x00. The first grant after reset goes to requester 0.
- Single request: req[0] with op=3, a=0xA5, b=0x0F, rsp_ready=1 -> gnt=0001 at T+1; rsp_valid=1 at T+2 with rsp_data=0x55 and rsp_id=0.
- Opcode sweep: a=0xF0, b=0xCC, ops 0..7 on requester 2 -> results C0, FC, 3C, C3, 3F, 03, 0F, F0, each with rsp_id=2.
- Fairness: all four req high, rsp_ready=1 -> gnt order 0,1,2,3, one grant every 2 cycles. After that, req[0] and req[2] both high -> 0 is granted before 2 (ptr wrapped).
- Backpressure: rsp_ready=0 for 5 cycles while in HOLD with req[1] pending -> rsp_valid/data/id stable and no gnt. Raising rsp_ready -> gnt[1] on the next cycle.
- Reset mid-operation: assert rst during EXEC -> rsp_valid never rises for that operation. State returns to IDLE and ptr=0.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared encodings for the gate-level blocks: logic-unit opcodes and arbiter states.
package gate_pkg;
   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_XNOR = 3'd3;
   localparam logic [2:0] OP_NAND = 3'd4;
   localparam logic [2:0] OP_NOR  = 3'd5;
   localparam logic [2:0] OP_NOT  = 3'd6;
   localparam logic [2:0] OP_BUF  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HOLD = 2'd2
   } state_t;
endpackage

// File: rtl/logic_gate_alu.sv
// Combinational bitwise two-input logic unit; NOT and BUF act on a only.
module logic_gate_alu
   import gate_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   always_comb begin
      y = a;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_NOT:  y = ~a;
         OP_BUF:  y = a;
         default: y = a;
      endcase
   end
endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin sharing of one logic_gate_alu between N_REQ requesters, with a
// valid/ready response port tagged by requester ID.
module gate_unit_arbiter
   import gate_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [3*N_REQ-1:0]     op,
   input  logic [WIDTH*N_REQ-1:0] a,
   input  logic [WIDTH*N_REQ-1:0] b,
   output logic [N_REQ-1:0]       gnt,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   busy
);
   state_t             state_q, state_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [IDW-1:0]     id_q, id_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]     rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic [WIDTH-1:0]   alu_y;
   logic [IDW:0]       pick;
   logic               found;
   logic [IDW-1:0]     win;
   logic               capture;
   int                 win_i;

   // MSB flags a hit; the descending loop lets the entry nearest ptr win.
   function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [IDW-1:0]   p);
      logic [IDW:0] res;
      int           idx;
      res = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = (int'(p) + i) % N_REQ;
         if (r[idx]) res = {1'b1, IDW'(idx)};
      end
      return res;
   endfunction

   logic_gate_alu #(.WIDTH(WIDTH)) u_alu (
      .op (op_q),
      .a  (a_q),
      .b  (b_q),
      .y  (alu_y)
   );

   assign pick  = rr_pick(req, ptr_q);
   assign found = pick[IDW];
   assign win   = pick[IDW-1:0];
   assign win_i = int'(win);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      gnt_d       = '0;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      capture     = 1'b0;
      case (state_q)
         ST_IDLE: capture = found;
         ST_EXEC: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = alu_y;
            rsp_id_d    = id_q;
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (found) capture = 1'b1;
               else       state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (capture) begin
         state_d    = ST_EXEC;
         id_d       = win;
         op_d       = op[3*win_i +: 3];
         a_d        = a[WIDTH*win_i +: WIDTH];
         b_d        = b[WIDTH*win_i +: WIDTH];
         gnt_d[win] = 1'b1;
         ptr_d      = (win_i == N_REQ - 1) ? '0 : IDW'(win_i + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         gnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Bench for gate_unit_arbiter: directed scenarios plus random traffic against
// a transaction-level model (round-robin search, one slot, opcode table).
module tb_gate_unit_arbiter;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [3*N-1:0] op;
   logic [W*N-1:0] a, b;
   logic [N-1:0]   gnt;
   logic           rsp_valid, rsp_ready;
   logic [IW-1:0]  rsp_id;
   logic [W-1:0]   rsp_data;
   logic           busy;

   int total = 0;
   int bad   = 0;

   gate_unit_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(IW)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b), .gnt(gnt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // Model: the unit is free, computing, or holding a result.
   int           m_slot;
   int           m_ptr;
   logic [N-1:0] e_gnt;
   logic         e_valid;
   logic [W-1:0] e_data;
   logic [IW-1:0] e_id;
   int           c_id;
   logic [2:0]   c_op;
   logic [W-1:0] c_a, c_b;

   function automatic logic [W-1:0] ref_gate(input int o, input logic [W-1:0] x, input logic [W-1:0] y);
      case (o)
         0: return x & y;
         1: return x | y;
         2: return x ^ y;
         3: return ~(x ^ y);
         4: return ~(x & y);
         5: return ~(x | y);
         6: return ~x;
         default: return x;
      endcase
   endfunction

   function automatic int rr_winner(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++)
         if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic model_edge();
      int w;
      if (rst) begin
         m_slot = 0; m_ptr = 0; e_gnt = '0; e_valid = 1'b0; e_data = '0; e_id = '0;
         return;
      end
      e_gnt = '0;
      if (m_slot == 1) begin
         e_valid = 1'b1;
         e_data  = ref_gate(int'(c_op), c_a, c_b);
         e_id    = IW'(c_id);
         m_slot  = 2;
      end else if (m_slot == 0 || rsp_ready) begin
         if (m_slot == 2) e_valid = 1'b0;
         w = rr_winner(req, m_ptr);
         if (w >= 0) begin
            c_id = w; c_op = op[3*w +: 3]; c_a = a[W*w +: W]; c_b = b[W*w +: W];
            e_gnt[w] = 1'b1;
            m_ptr = (w + 1) % N;
            m_slot = 1;
         end else begin
            m_slot = 0;
         end
      end
   endtask

   // One clock; requesters drop req once their grant is visible.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      for (int i = 0; i < N; i++)
         if (e_gnt[i]) req[i] = 1'b0;
   endtask

   task automatic drain();
      req = '0; rsp_ready = 1'b1;
      repeat (3) step();
   endtask

   task automatic set_req(input int i, input int o, input logic [W-1:0] x, input logic [W-1:0] y);
      op[3*i +: 3] = 3'(o); a[W*i +: W] = x; b[W*i +: W] = y; req[i] = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '1; rsp_ready = 1'b1;
      op = 12'(($urandom)); a = $urandom; b = $urandom;
      repeat (2) step();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rsp_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", rsp_data); end
      rst = 1'b0;
      step();
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt got=%b want=0001", gnt); end
      drain();
   endtask

   task automatic test_single();
      set_req(0, 3, 8'hA5, 8'h0F); rsp_ready = 1'b1;
      step();
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b want=0001", gnt); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", rsp_valid); end
      step();
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", rsp_valid); end
      total++; if (rsp_data !== 8'h55) begin bad++; $display("FAIL single_data got=%h want=55", rsp_data); end
      total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL single_id got=%0d want=0", rsp_id); end
      step();
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_done valid=%b busy=%b want=0,0", rsp_valid, busy); end
   endtask

   task automatic test_opcode_sweep();
      logic [W-1:0] tbl [8];
      tbl = '{8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h3F, 8'h03, 8'h0F, 8'hF0};
      rsp_ready = 1'b1;
      for (int o = 0; o < 8; o++) begin
         set_req(2, o, 8'hF0, 8'hCC);
         step();
         total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL sweep_gnt op=%0d got=%b want=0100", o, gnt); end
         a[W*2 +: W] = $urandom; b[W*2 +: W] = $urandom;
         step();
         total++; if (rsp_data !== tbl[o] || rsp_id !== 2'd2 || rsp_valid !== 1'b1)
            begin bad++; $display("FAIL sweep_rsp op=%0d got=%h/id%0d/v%b want=%h/id2/v1", o, rsp_data, rsp_id, rsp_valid, tbl[o]); end
         step();
      end
   endtask

   task automatic test_fairness();
      int ids[$];
      int cyc[$];
      rst = 1'b1; req = '0; step(); rst = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 7), W'($urandom), W'($urandom));
      rsp_ready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         step();
         for (int i = 0; i < N; i++) if (gnt[i]) begin ids.push_back(i); cyc.push_back(c); end
      end
      total++; if (ids.size() != 4) begin bad++; $display("FAIL fair_count got=%0d want=4", ids.size()); end
      for (int k = 0; k < ids.size() && k < 4; k++) begin
         total++; if (ids[k] != k) begin bad++; $display("FAIL fair_order idx=%0d got=%0d want=%0d", k, ids[k], k); end
         if (k > 0) begin
            total++; if (cyc[k] - cyc[k-1] != 2) begin bad++; $display("FAIL fair_spacing idx=%0d got=%0d want=2", k, cyc[k] - cyc[k-1]); end
         end
      end
      set_req(0, 1, 8'h12, 8'h34); set_req(2, 2, 8'h56, 8'h78);
      step();
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL fair_wrap_first got=%b want=0001", gnt); end
      step(); step();
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL fair_wrap_second got=%b want=0100", gnt); end
      drain();
   endtask

   task automatic test_backpressure();
      logic [W-1:0]  d0;
      logic [IW-1:0] i0;
      set_req(0, 0, 8'h3C, 8'hF5);
      rsp_ready = 1'b0;
      step();
      set_req(1, 2, 8'h81, 8'h18);
      step();
      d0 = rsp_data; i0 = rsp_id;
      total++; if (rsp_valid !== 1'b1 || d0 !== 8'h34 || i0 !== 2'd0)
         begin bad++; $display("FAIL bp_rsp got=%h/id%0d/v%b want=34/id0/v1", d0, i0, rsp_valid); end
      for (int c = 0; c < 5; c++) begin
         step();
         total++; if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_id !== i0 || gnt !== 4'b0000)
            begin bad++; $display("FAIL bp_hold cyc=%0d got=v%b/%h/id%0d/g%b want=v1/%h/id%0d/g0000", c, rsp_valid, rsp_data, rsp_id, gnt, d0, i0); end
      end
      rsp_ready = 1'b1;
      step();
      total++; if (gnt !== 4'b0010 || rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=g%b/v%b want=g0010/v0", gnt, rsp_valid); end
      step();
      total++; if (rsp_data !== 8'h99 || rsp_id !== 2'd1) begin bad++; $display("FAIL bp_next got=%h/id%0d want=99/id1", rsp_data, rsp_id); end
      drain();
   endtask

   task automatic test_reset_mid();
      set_req(3, 4, 8'hFF, 8'h0F); rsp_ready = 1'b1;
      step();
      total++; if (gnt !== 4'b1000 || busy !== 1'b1) begin bad++; $display("FAIL mid_gnt got=g%b/b%b want=g1000/b1", gnt, busy); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_discard cyc=%0d got=v%b/b%b want=v0/b0", c, rsp_valid, busy); end
         step();
      end
      req = '1;
      step();
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL mid_ptr got=%b want=0001", gnt); end
      drain();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (!req[i] && !e_gnt[i] && $urandom_range(0, 2) == 0)
               set_req(i, $urandom_range(0, 7), W'($urandom), W'($urandom));
            else if (req[i] && $urandom_range(0, 19) == 0)
               req[i] = 1'b0;
         end
         step();
         total++; if (gnt !== e_gnt) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b want=%b", c, gnt, e_gnt); end
         total++; if (rsp_valid !== e_valid || busy !== (m_slot != 0))
            begin bad++; $display("FAIL rnd_valid cyc=%0d got=v%b/b%b want=v%b/b%b", c, rsp_valid, busy, e_valid, m_slot != 0); end
         if (e_valid) begin
            total++; if (rsp_data !== e_data || rsp_id !== e_id)
               begin bad++; $display("FAIL rnd_rsp cyc=%0d got=%h/id%0d want=%h/id%0d", c, rsp_data, rsp_id, e_data, e_id); end
         end
      end
      drain();
   endtask

   initial begin
      rst = 1'b1; req = '0; op = '0; a = '0; b = '0; rsp_ready = 1'b1;
      m_slot = 0; m_ptr = 0; e_gnt = '0; e_valid = 1'b0; e_data = '0; e_id = '0;
      c_id = 0; c_op = '0; c_a = '0; c_b = '0;
      test_reset();
      test_single();
      test_opcode_sweep();
      test_fairness();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
